spi_rx_sync_fifo: RTL and testbench

Consumes the sclk-domain receive byte (data bus plus byte-ready strobe) and the chip-select from the SPI receive shifter, and moves the bytes into the system clock domain. Resynchronises the ready strobe and chip-select, captures each completed byte into a small first-word-fall-through FIFO, and presents it on a valid/ready stream to the echo/command logic. Also reports per-frame byte counts and a sticky overflow flag.

---
 rtl/spi_rx_sync_fifo.sv | 160 ++++++++++++++++
 tb/tb_spi_rx_sync_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_sync_fifo.sv
// Brings SPI receive bytes from the sclk domain into clk through synchronised strobes
// and a small first-word-fall-through FIFO. Also tracks the byte count per frame and a sticky overflow flag.
module spi_rx_sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         rx_byte,
    input  logic                     rx_ready,
    input  logic                     cs,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [7:0]               frame_len,
    output logic                     frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Synchronisers and edge detection
    logic [SYNC_STAGES-1:0] r_rdy_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_rdy_d;
    logic                   r_cs_d;
    logic                   w_rdy_s;
    logic                   w_cs_s;
    logic                   w_push;
    logic                   w_cs_rise;
    logic                   w_cs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_sync <= '0;
            r_cs_sync  <= '1;
            r_rdy_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], rx_ready};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_rdy_d    <= r_rdy_sync[SYNC_STAGES-1];
            r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_rdy_s   = r_rdy_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_push    = w_rdy_s & ~r_rdy_d;
    assign w_cs_rise = w_cs_s & ~r_cs_d;
    assign w_cs_fall = ~w_cs_s & r_cs_d;

    // FIFO storage and control
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overflow;

    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_count_after_pop;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_full            = (r_count == FULL_CNT);
    assign w_pop             = r_out_valid & out_ready;
    assign w_accept          = w_push & (~w_full | w_pop);
    assign w_drop            = w_push & w_full & ~w_pop;
    assign w_rd_ptr_next     = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_count_after_pop = w_pop ? r_count - 1'b1 : r_count;
    assign w_count_next      = w_accept ? w_count_after_pop + 1'b1 : w_count_after_pop;

    // The head is registered so out_data keeps the last byte after the FIFO drains;
    // a byte landing in an otherwise empty FIFO bypasses the array.
    always_comb begin
        w_head_next = r_out_data;
        if (w_count_next != '0) begin
            if (w_accept && (w_count_after_pop == '0)) begin
                w_head_next = rx_byte;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_data  <= w_head_next;
            r_out_valid <= (w_count_next != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame byte counter; push events count whether accepted or dropped
    logic [7:0] r_byte_cnt;
    logic [7:0] r_frame_len;
    logic       r_frame_done;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc = (r_byte_cnt == 8'hFF) ? 8'hFF : r_byte_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= 8'd0;
            r_frame_len  <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_byte_cnt <= w_push ? 8'd1 : 8'd0;
            end else if (w_push) begin
                r_byte_cnt <= w_cnt_inc;
            end
            r_frame_done <= w_cs_rise;
            if (w_cs_rise) begin
                r_frame_len <= w_push ? w_cnt_inc : r_byte_cnt;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign frame_len  = r_frame_len;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_rx_sync_fifo.sv
// Directed bench: expected bytes go into a scoreboard queue at stimulus time and
// are popped and compared by a negedge monitor whenever the DUT hands a byte over.
module tb_spi_rx_sync_fifo;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       rx_byte;
    logic                   rx_ready;
    logic                   cs;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   overflow_clr;
    logic [7:0]             frame_len;
    logic                   frame_done;

    spi_rx_sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte     (rx_byte),
        .rx_ready    (rx_ready),
        .cs          (cs),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .frame_len   (frame_len),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int valid_cyc   = 0;
    int done_cnt    = 0;
    logic [WIDTH-1:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: one line per byte handed over
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) valid_cyc++;
            if (frame_done) done_cnt++;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got %0h expected none", out_data);
                end else begin
                    logic [WIDTH-1:0] exp_b;
                    exp_b = sb.pop_front();
                    if (out_data !== exp_b) begin
                        miscompares++;
                        $display("FAIL pop_data: got %0h expected %0h", out_data, exp_b);
                    end else begin
                        $display("pop  data=%0h", out_data);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk-domain byte: ready high for 4 clk, low for 4 clk
    task automatic send(input logic [7:0] b, input bit expect_kept);
        if (expect_kept) sb.push_back(b);
        rx_byte  = b;
        rx_ready = 1'b1;
        tick(4);
        rx_ready = 1'b0;
        tick(4);
    endtask

    initial begin
        int lat;
        int done0;
        rst_n        = 1'b0;
        rx_byte      = '0;
        rx_ready     = 1'b0;
        cs           = 1'b1;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        #12;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_data",   32'(out_data), 32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        check("rst_ovf",    32'(overflow), 32'd0);
        check("rst_flen",   32'(frame_len), 32'd0);
        check("rst_fdone",  32'(frame_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // Single byte
        done0 = done_cnt;
        valid_cyc = 0;
        cs = 1'b0;
        tick(4);
        out_ready = 1'b1;
        sb.push_back(8'hA5);
        rx_byte  = 8'hA5;
        rx_ready = 1'b1;
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (out_valid && lat < 0) lat = i;
        end
        rx_ready = 1'b0;
        tick(4);
        cs = 1'b1;
        tick(6);
        check("t1_latency_in_range", 32'((lat >= 1) && (lat <= SYNC_STAGES + 2)), 32'd1);
        check("t1_valid_cycles", 32'(valid_cyc), 32'd1);
        check("t1_frame_done_pulses", 32'(done_cnt - done0), 32'd1);
        check("t1_frame_len", 32'(frame_len), 32'd1);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Streaming frame
        done0 = done_cnt;
        cs = 1'b0;
        tick(4);
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        cs = 1'b1;
        tick(6);
        check("t2_frame_len", 32'(frame_len), 32'd4);
        check("t2_count", 32'(fifo_count), 32'd0);
        check("t2_frame_done_pulses", 32'(done_cnt - done0), 32'd1);

        // Overflow: 6 bytes into a 4-deep FIFO
        out_ready = 1'b0;
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i < DEPTH);
        cs = 1'b1;
        tick(6);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_frame_len", 32'(frame_len), 32'd6);
        check("t3_head", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        check("t3_count_drained", 32'(fifo_count), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Full with simultaneous push and pop
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        sb.push_back(8'h14);
        rx_byte  = 8'h14;
        rx_ready = 1'b1;
        tick(SYNC_STAGES);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(2);
        rx_ready = 1'b0;
        tick(4);
        check("t4_count_still_full", 32'(fifo_count), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_head", 32'(out_data), 32'h11);

        // Overflow clear colliding with a drop
        send(8'h21, 1'b0);
        check("t5_ovf_set", 32'(overflow), 32'd1);
        rx_byte  = 8'h22;
        rx_ready = 1'b1;
        tick(SYNC_STAGES);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        tick(2);
        rx_ready = 1'b0;
        tick(4);
        check("t5_ovf_set_wins", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        cs = 1'b1;
        tick(6);
        check("t5_frame_len", 32'(frame_len), 32'd7);
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        check("t5_count_drained", 32'(fifo_count), 32'd0);

        // Reset mid-frame
        cs = 1'b0;
        tick(4);
        send(8'h30, 1'b0);
        send(8'h31, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data",  32'(out_data), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_flen",  32'(frame_len), 32'd0);
        check("t6_rst_ovf",   32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(6);
        cs = 1'b1;
        tick(6);
        cs = 1'b0;
        tick(4);
        out_ready = 1'b1;
        send(8'h55, 1'b1);
        send(8'hAA, 1'b1);
        cs = 1'b1;
        tick(6);
        check("t6_frame_len", 32'(frame_len), 32'd2);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
